// File: rtl/instr_fetch_stage.sv
// Fetch stage in front of a synchronous (1-cycle) instruction ROM: owns the PC, pairs each ROM
// word with its address, supports stall/redirect. Optional perf counters: IFETCH_PERF_CNT_EN.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_valid,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_fetch_cnt,
  output logic [31:0]       o_stall_cnt
);

  // Handshake: decode takes {o_pc,o_instr} in any cycle with o_valid & ~i_stall & ~i_redirect;
  // i_stall holds the presented word, i_redirect drops it and overrides stall.
  logic [31:0] pc_q;
  logic [31:0] out_pc_q;
  logic        out_valid_q;
  logic [31:0] redirect_pc_aligned;
  logic [31:0] sel_pc;

  assign redirect_pc_aligned = i_redirect_pc & 32'hFFFF_FFFC;

  // A stall re-issues the presented address so the ROM keeps returning the same word.
  always_comb begin
    sel_pc = pc_q;
    if (i_redirect) begin
      sel_pc = redirect_pc_aligned;
    end else if (i_stall && out_valid_q) begin
      sel_pc = out_pc_q;
    end
  end

  assign o_rom_addr = sel_pc[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      out_pc_q    <= 32'h0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= sel_pc + 32'd4;
      out_pc_q    <= sel_pc;
      out_valid_q <= 1'b1;
    end
  end

  assign o_valid = out_valid_q;
  assign o_pc    = out_pc_q;
  assign o_instr = i_rom_data;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        accept;
  logic        stall_seen;

  assign accept     = out_valid_q && !i_stall && !i_redirect;
  assign stall_seen = out_valid_q && i_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (accept)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_seen) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_fetch_cnt = 32'h0;
  assign o_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: behavioural ROM, reference PC model feeding an expected queue,
// plus directed spot checks of the documented fetch sequences.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_valid      (valid),
    .o_pc         (pc),
    .o_instr      (instr),
    .o_fetch_cnt  (fetch_cnt),
    .o_stall_cnt  (stall_cnt)
  );

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    case (a[13:2])
      12'd0:   return 32'h20006513;
      12'd1:   return 32'h0c800593;
      12'd2:   return 32'h05600613;
      12'd3:   return 32'h0a400693;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];

  // Reference model state
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_seq;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_seq   = 32'h0;
    m_fetch = 32'h0;
    m_stall = 32'h0;
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h0, 32'h0});
  endtask

  task automatic check_counters(input string tag, input logic [31:0] f, input logic [31:0] s);
`ifdef IFETCH_PERF_CNT_EN
    check({tag, "_fetch_cnt"}, fetch_cnt, f);
    check({tag, "_stall_cnt"}, stall_cnt, s);
`else
    check({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
    check({tag, "_stall_cnt"}, stall_cnt, 32'h0);
`endif
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
    logic [64:0] e;
    logic [31:0] sel;
    check("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_valid", {31'b0, valid}, {31'b0, e[64]});
      if (e[64]) begin
        check("sb_pc", pc, e[63:32]);
        check("sb_instr", instr, e[31:0]);
      end
    end
    check_counters("sb", m_fetch, m_stall);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (rd)                sel = {rpc[31:2], 2'b00};
    else if (st && m_valid) sel = m_pc;
    else                   sel = m_seq;
    #1;
    check("rom_addr", {18'b0, rom_addr}, {18'b0, sel[13:0]});
    if (m_valid && !st && !rd) m_fetch = m_fetch + 32'd1;
    if (m_valid && st)         m_stall = m_stall + 32'd1;
    m_valid = 1'b1;
    m_pc    = sel;
    m_seq   = sel + 32'd4;
    exp_q.push_back({1'b1, sel, rom_word(sel[13:0])});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_rom_addr", {18'b0, rom_addr}, 32'h0);
    check_counters("rst", 32'h0, 32'h0);
    rst_n = 1'b1;
    model_reset();

    // Reset release and sequential fetch
    cycle(1'b0, 1'b0, 32'h0);
    check("t1_pc0", pc, 32'h0);
    check("t1_instr0", instr, 32'h20006513);
    cycle(1'b0, 1'b0, 32'h0);
    check("t1_pc4", pc, 32'h4);

    // Stall three cycles on pc=0x4
    repeat (3) begin
      check("t2_hold_pc", pc, 32'h4);
      check("t2_hold_instr", instr, 32'h0c800593);
      cycle(1'b1, 1'b0, 32'h0);
    end
    check("t2_after_pc", pc, 32'h4);
    cycle(1'b0, 1'b0, 32'h0);
    check("t2_next_pc", pc, 32'h8);
    check("t2_next_instr", instr, 32'h05600613);

    // Redirect to unaligned 0xE while 0x8 is shown
    cycle(1'b0, 1'b1, 32'h0000_000E);
    check("t3_pc", pc, 32'hC);
    check("t3_instr", instr, 32'h0a400693);
    cycle(1'b0, 1'b0, 32'h0);
    check("t3_seq_pc", pc, 32'h10);
    check_counters("t6_mid", 32'd3, 32'd3);

    // Redirect and stall together
    cycle(1'b1, 1'b1, 32'h4);
    check("t4_valid", {31'b0, valid}, 32'h1);
    check("t4_pc", pc, 32'h4);
    cycle(1'b0, 1'b0, 32'h0);

    // Redirect beyond ROM contents, then address aliasing
    cycle(1'b0, 1'b1, 32'h0000_7FFC);
    check("t5_pc", pc, 32'h7FFC);
    check("t5_instr", instr, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("t5_wrap_pc", pc, 32'h8000);
    check("t5_wrap_instr", instr, 32'h20006513);

    // Back-to-back redirects
    cycle(1'b0, 1'b1, 32'h8);
    check("b2b_first_pc", pc, 32'h8);
    cycle(1'b0, 1'b1, 32'hC);
    check("b2b_last_pc", pc, 32'hC);
    cycle(1'b0, 1'b0, 32'h0);
    check("b2b_seq_pc", pc, 32'h10);

    // Random stall/redirect mix
    repeat (40) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            32'($urandom_range(0, 63)));
    end

    // Asynchronous reset in the middle of a stall
    stall = 1'b1;
    redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'b0, valid}, 32'h0);
    check("mrst_pc", pc, 32'h0);
    check("mrst_rom_addr", {18'b0, rom_addr}, 32'h0);
    check_counters("mrst", 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;
    model_reset();
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    check("post_rst_pc", pc, 32'hC);
    check("post_rst_instr", instr, 32'h0a400693);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
